// File: rtl/fragment_writer.sv
// fragment_writer: FIFO-buffered framebuffer SRAM write stage; frame clear built only when FRAG_CLEAR_EN is defined
module fragment_writer #(
  parameter int          FIFO_DEPTH     = 8,
  parameter int          SRAM_WR_CYCLES = 2,
  parameter int          FB_PIXELS      = 256000,
  parameter logic [15:0] CLEAR_COLOR    = 16'h0000
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  input  logic        I_FRAG_VALID,
  input  logic [17:0] I_FRAG_ADDR,
  input  logic [15:0] I_FRAG_COLOR,
  output logic        O_FRAG_READY,
  input  logic        I_FRAME_START,
  output logic [17:0] O_SRAM_ADDR,
  output logic [15:0] O_SRAM_DATA,
  output logic        O_SRAM_WE_N,
  output logic        O_BUSY,
  output logic [7:0]  O_DROP_COUNT
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = $clog2(SRAM_WR_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
`ifdef FRAG_CLEAR_EN
    RECOVER,
    CLEAR
`else
    RECOVER
`endif
  } state_t;

  state_t state, next;
  logic [17:0] fifo_addr [FIFO_DEPTH];
  logic [15:0] fifo_color [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wcnt;
  logic full, empty, in_range, accept, push, pop, last_write, pend;

  assign full       = count == CW'(FIFO_DEPTH);
  assign empty      = count == '0;
  assign in_range   = 32'(I_FRAG_ADDR) < 32'(FB_PIXELS);
  assign accept     = I_FRAG_VALID && O_FRAG_READY;
  assign push       = accept && in_range;
  assign pop        = state == LOAD;
  assign last_write = wcnt == WW'(SRAM_WR_CYCLES - 1);
  assign O_BUSY     = !empty || state != IDLE || pend;

`ifdef FRAG_CLEAR_EN
  logic clear_pending, in_clear, clr_last;
  logic [17:0] clr_cnt;
  assign clr_last     = O_SRAM_ADDR == 18'(FB_PIXELS - 1);
  assign pend         = clear_pending;
  assign O_FRAG_READY = !full && !clear_pending && state != CLEAR;
  // Latch clear requests (extra pulses ignored) and step the clear address; clr_cnt is the next address to clear
  always_ff @(posedge I_CLOCK or posedge I_RESET)
    if (I_RESET) begin
      clear_pending <= 1'b0;
      in_clear      <= 1'b0;
      clr_cnt       <= '0;
    end else if (state == RECOVER && in_clear && clr_last) begin
      clear_pending <= 1'b0;
      in_clear      <= 1'b0;
      clr_cnt       <= '0;
    end else begin
      if (I_FRAME_START && !clear_pending) clear_pending <= 1'b1;
      if (next == CLEAR) begin
        in_clear <= 1'b1;
        clr_cnt  <= clr_cnt + 1'b1;
      end
    end
`else
  logic unused_frame_start;
  assign unused_frame_start = I_FRAME_START;
  assign pend               = 1'b0;
  assign O_FRAG_READY       = !full;
`endif

  // Next-state logic: clear waits for an empty FIFO; back-to-back fragments skip IDLE
  always_comb begin
    next = state;
    case (state)
`ifdef FRAG_CLEAR_EN
      IDLE:    next = (clear_pending && empty) ? CLEAR : !empty ? LOAD : IDLE;
      RECOVER: next = in_clear ? (clr_last ? IDLE : CLEAR) : !empty ? LOAD : IDLE;
      CLEAR:   next = WRITE;
`else
      IDLE:    next = empty ? IDLE : LOAD;
      RECOVER: next = empty ? IDLE : LOAD;
`endif
      LOAD:    next = WRITE;
      WRITE:   next = last_write ? RECOVER : WRITE;
      default: next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge I_CLOCK or posedge I_RESET)
    if (I_RESET) state <= IDLE;
    else state <= next;

  // FIFO pointers and occupancy; the pop lands on the edge that leaves LOAD
  always_ff @(posedge I_CLOCK or posedge I_RESET)
    if (I_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end

  // FIFO storage, unreset since occupancy alone defines valid entries
  always_ff @(posedge I_CLOCK)
    if (push) begin
      fifo_addr[wr_ptr]  <= I_FRAG_ADDR;
      fifo_color[wr_ptr] <= I_FRAG_COLOR;
    end

  // SRAM bus: address/data set up on entry to LOAD or CLEAR and held through RECOVER
  always_ff @(posedge I_CLOCK or posedge I_RESET)
    if (I_RESET) begin
      O_SRAM_ADDR <= '0;
      O_SRAM_DATA <= '0;
      O_SRAM_WE_N <= 1'b1;
      wcnt        <= '0;
    end else begin
      O_SRAM_WE_N <= next != WRITE;
      wcnt        <= (state == WRITE) ? wcnt + 1'b1 : '0;
      if (next == LOAD) begin
        O_SRAM_ADDR <= fifo_addr[rd_ptr];
        O_SRAM_DATA <= fifo_color[rd_ptr];
      end
`ifdef FRAG_CLEAR_EN
      if (next == CLEAR) begin
        O_SRAM_ADDR <= clr_cnt;
        O_SRAM_DATA <= CLEAR_COLOR;
      end
`endif
    end

  // Saturating count of out-of-range fragments that completed the handshake
  always_ff @(posedge I_CLOCK or posedge I_RESET)
    if (I_RESET) O_DROP_COUNT <= '0;
    else if (accept && !in_range && O_DROP_COUNT != 8'hFF) O_DROP_COUNT <= O_DROP_COUNT + 1'b1;
endmodule

// File: tb/tb_fragment_writer.sv
// tb_fragment_writer: directed table-driven bench for fragment_writer
module tb_fragment_writer;
`ifdef FRAG_CLEAR_EN
  localparam int FBP = 16;
`else
  localparam int FBP = 256000;
`endif
  localparam logic [17:0] SA = (FBP == 16) ? 18'd10 : 18'd1000;

  logic        clk, rst, valid, frame_start;
  logic [17:0] addr;
  logic [15:0] color;
  logic        ready, we_n, busy;
  logic [17:0] sram_addr;
  logic [15:0] sram_data;
  logic [7:0]  drops;

  int checks = 0, failures = 0, cyc = 0;
  logic [17:0] wq_addr[$];
  logic [15:0] wq_data[$];
  int          wq_cyc[$];
  logic        prev_we = 1'b1;
  int          low_len = 0;
  logic        mon_skip = 1'b0;

  typedef struct {int k; logic we; logic bsy; logic bus;} tv_t;
  typedef struct {logic [17:0] a; logic [15:0] c; logic wr; int drop;} rv_t;
  tv_t tv[6];
  rv_t rv[6];

  fragment_writer #(.FB_PIXELS(FBP)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_FRAG_VALID(valid), .I_FRAG_ADDR(addr),
    .I_FRAG_COLOR(color), .O_FRAG_READY(ready), .I_FRAME_START(frame_start),
    .O_SRAM_ADDR(sram_addr), .O_SRAM_DATA(sram_data), .O_SRAM_WE_N(we_n),
    .O_BUSY(busy), .O_DROP_COUNT(drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: log each WE_N falling edge, check strobe width and bus stability while low
  always @(negedge clk) begin
    if (prev_we && !we_n) begin
      wq_addr.push_back(sram_addr);
      wq_data.push_back(sram_data);
      wq_cyc.push_back(cyc);
      low_len <= 1;
    end else if (!we_n) begin
      low_len <= low_len + 1;
      if (wq_addr.size() > 0) begin
        chk("bus_stable_addr", 32'(sram_addr), 32'(wq_addr[$]));
        chk("bus_stable_data", 32'(sram_data), 32'(wq_data[$]));
      end
    end else if (!prev_we && !mon_skip) chk("we_low_width", low_len, 2);
    prev_we <= we_n;
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic send(input logic [17:0] a, input logic [15:0] c);
    int t = 0;
    @(negedge clk);
    valid = 1'b1; addr = a; color = c;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", 32'(ready), 1);
    if (ready) @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    @(negedge clk);
    for (int n = 0; n < maxc && busy; n++) @(negedge clk);
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, acc, first_low, bad;
    valid = 1'b0; addr = '0; color = '0; frame_start = 1'b0;
    tv[0] = '{0, 1'b1, 1'b1, 1'b0};
    tv[1] = '{1, 1'b1, 1'b1, 1'b1};
    tv[2] = '{2, 1'b0, 1'b1, 1'b1};
    tv[3] = '{3, 1'b0, 1'b1, 1'b1};
    tv[4] = '{4, 1'b1, 1'b1, 1'b1};
    tv[5] = '{5, 1'b1, 1'b0, 1'b0};
    rv[0] = '{18'd5, 16'h1234, 1'b1, 0};
    rv[1] = '{18'd256000, 16'hFFFF, 1'b0, 1};
    rv[2] = '{18'h3FFFF, 16'hEEEE, 1'b0, 2};
    rv[3] = '{18'(FBP - 1), 16'h0F0F, 1'b1, 2};
    rv[4] = '{18'(FBP), 16'hABCD, 1'b0, 3};
    rv[5] = '{18'(FBP - 1), 16'h5555, 1'b1, 3};

    rst = 1'b1;
    #1;
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_data", 32'(sram_data), 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drops", 32'(drops), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single fragment: timing table relative to the accept edge
    @(negedge clk);
    valid = 1'b1; addr = SA; color = 16'hF800;
    chk("single_ready", 32'(ready), 1);
    @(posedge clk);
    #1 valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("single_we_k%0d", tv[i].k), 32'(we_n), 32'(tv[i].we));
      chk($sformatf("single_busy_k%0d", tv[i].k), 32'(busy), 32'(tv[i].bsy));
      if (tv[i].bus) begin
        chk($sformatf("single_addr_k%0d", tv[i].k), 32'(sram_addr), 32'(SA));
        chk($sformatf("single_data_k%0d", tv[i].k), 32'(sram_data), 32'h0000F800);
      end
    end
    clear_log();

    // range table: in-range writes in order, drops counted
    foreach (rv[i]) begin
      send(rv[i].a, rv[i].c);
      @(negedge clk);
      chk($sformatf("range_drop_%0d", i), 32'(drops), 32'(rv[i].drop));
    end
    wait_idle(100);
    n = 0;
    foreach (rv[i]) if (rv[i].wr) begin
      if (n < wq_addr.size()) begin
        chk($sformatf("range_wr_addr_%0d", i), 32'(wq_addr[n]), 32'(rv[i].a));
        chk($sformatf("range_wr_data_%0d", i), 32'(wq_data[n]), 32'(rv[i].c));
      end
      n++;
    end
    chk("range_wr_count", wq_addr.size(), n);
    clear_log();

    // burst of 12 with valid held high
    acc = 0; first_low = -1;
    @(negedge clk);
    valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int t = 0;
      addr = 18'(i); color = 16'hA000 + 16'(i);
      while (!ready && t < 100) begin
        if (first_low < 0) first_low = acc;
        @(negedge clk);
        t++;
      end
      if (!ready) chk("burst_ready_timeout", 32'(ready), 1);
      @(posedge clk);
      acc++;
      @(negedge clk);
    end
    valid = 1'b0;
    chk("burst_full_at", first_low, 10);
    wait_idle(200);
    chk("burst_count", wq_addr.size(), 12);
    for (int i = 0; i < 12 && i < wq_addr.size(); i++) begin
      chk($sformatf("burst_addr_%0d", i), 32'(wq_addr[i]), i);
      chk($sformatf("burst_data_%0d", i), 32'(wq_data[i]), 32'hA000 + i);
      if (i > 0) chk($sformatf("burst_spacing_%0d", i), wq_cyc[i] - wq_cyc[i-1], 4);
    end
    clear_log();

    // drop count saturation
    for (int i = 0; i < 300; i++) send(18'h3FFFF, 16'h0);
    @(negedge clk);
    chk("drop_saturate", 32'(drops), 255);
    chk("drop_no_write", wq_addr.size(), 0);

`ifdef FRAG_CLEAR_EN
    // frame clear with 3 queued fragments
    clear_log();
    @(negedge clk);
    valid = 1'b1;
    addr = 18'd3; color = 16'h1111; @(posedge clk); #1;
    addr = 18'd7; color = 16'h2222; @(posedge clk); #1;
    addr = 18'd3; color = 16'h3333; @(posedge clk); #1;
    valid = 1'b0; frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    chk("clear_ready_drop", 32'(ready), 0);
    bad = 0;
    for (int t = 0; t < 400 && busy; t++) begin
      if (ready) bad++;
      frame_start = (t == 30);
      @(negedge clk);
    end
    frame_start = 1'b0;
    chk("clear_ready_low", bad, 0);
    chk("clear_done", 32'(busy), 0);
    chk("clear_ready_back", 32'(ready), 1);
    repeat (20) @(negedge clk);
    chk("clear_write_count", wq_addr.size(), 19);
    if (wq_addr.size() == 19) begin
      chk("clear_frag0", {14'(wq_addr[0]), wq_data[0]}, {14'd3, 16'h1111});
      chk("clear_frag1", {14'(wq_addr[1]), wq_data[1]}, {14'd7, 16'h2222});
      chk("clear_frag2", {14'(wq_addr[2]), wq_data[2]}, {14'd3, 16'h3333});
      for (int i = 0; i < 16; i++)
        chk($sformatf("clear_px_%0d", i), {14'(wq_addr[3+i]), wq_data[3+i]}, {14'(i), 16'h0000});
    end
`else
    // frame start ignored without the clear feature
    clear_log();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("fs_ready", 32'(ready), 1);
    chk("fs_busy", 32'(busy), 0);
    repeat (20) @(negedge clk);
    chk("fs_no_write", wq_addr.size(), 0);
`endif

    // async reset during WRITE with fragments queued
    clear_log();
    @(negedge clk);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 18'(40 + i); color = 16'hBEE0 + 16'(i);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    for (int t = 0; t < 50 && we_n; t++) @(negedge clk);
    chk("rstw_we_low_seen", 32'(we_n), 0);
    mon_skip = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rstw_we_high", 32'(we_n), 1);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_ready", 32'(ready), 1);
    @(negedge clk);
    do_reset();
    @(negedge clk);
    mon_skip = 1'b0;
    clear_log();
    repeat (20) @(negedge clk);
    chk("rstw_fifo_empty", wq_addr.size(), 0);
    send(18'd77, 16'h7777);
    wait_idle(100);
    chk("rstw_new_count", wq_addr.size(), 1);
    if (wq_addr.size() == 1) chk("rstw_new_write", {14'(wq_addr[0]), wq_data[0]}, {14'd77, 16'h7777});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fragment_writer.md
# fragment_writer

Framebuffer write stage directly downstream of the rasterizer. Accepts fragments (18-bit pixel address, 16-bit RGB565 color) through a small FIFO, drops out-of-range addresses, and drains each fragment into the external framebuffer SRAM with a fixed multi-cycle write strobe. Optionally clears the whole framebuffer at frame start. Backpressure goes upstream through `O_FRAG_READY`, so the rasterizer can stall.

## Interface
- `FIFO_DEPTH`, 8: fragment FIFO entries; power of two, ≥2.
- `SRAM_WR_CYCLES`, 2: cycles `O_SRAM_WE_N` is held low per write; ≥1.
- `FB_PIXELS`, 256000: valid address range is 0..FB_PIXELS-1 (640×400).
- `CLEAR_COLOR`, 16'h0000: color written by frame clear.
- `I_CLOCK` in 1: single clock; all state updates on posedge.
- `I_RESET` in 1: asynchronous, active-high reset.
- `I_FRAG_VALID` in 1: fragment present on `I_FRAG_ADDR` and `I_FRAG_COLOR`.
- `I_FRAG_ADDR` in 18: pixel address, y*640+x.
- `I_FRAG_COLOR` in 16: pixel color.
- `O_FRAG_READY` out 1: fragment accepted on a posedge when valid & ready.
- `I_FRAME_START` in 1: one-cycle pulse requesting a framebuffer clear; used only with `FRAG_CLEAR_EN`.
- `O_SRAM_ADDR` out 18: SRAM address.
- `O_SRAM_DATA` out 16: SRAM write data.
- `O_SRAM_WE_N` out 1: active-low write enable.
- `O_BUSY` out 1: high when the FIFO is non-empty, the state is not IDLE, or a clear is pending.
- `O_DROP_COUNT` out 8: saturating count of dropped fragments.

## Operation
- **Reset values (async):**
  - `O_SRAM_WE_N`=1; `O_SRAM_ADDR`=0; `O_SRAM_DATA`=0.
  - `O_FRAG_READY`=1; `O_BUSY`=0; `O_DROP_COUNT`=0.
  - FIFO empty; state IDLE; clear-pending=0.
- **Reset mid-operation:** `O_SRAM_WE_N` rises immediately. FIFO contents and any in-progress clear are discarded.
- **Accept:**
  - `O_FRAG_READY` = !full && !clear_pending && state!=CLEAR.
  - A fragment with addr ≥ FB_PIXELS is accepted (handshake completes) but not pushed. `O_DROP_COUNT` increments and saturates at 255.
- **FSM:**
  - IDLE:
    - If clear_pending and FIFO empty → CLEAR.
    - Else if FIFO non-empty → LOAD.
  - LOAD: pop the FIFO head; drive `O_SRAM_ADDR`/`O_SRAM_DATA`; WE_N=1 (address setup) → WRITE.
  - WRITE: WE_N=0 for exactly SRAM_WR_CYCLES cycles; address and data stable → RECOVER.
  - RECOVER: WE_N=1 for one cycle; address and data held.
    - During a clear: → CLEAR.
    - Else if FIFO non-empty → LOAD.
    - Else → IDLE.
  - CLEAR: load the clear address counter (starts at 0) and CLEAR_COLOR onto the SRAM bus → WRITE. After the RECOVER for address FB_PIXELS-1, the counter resets and the FSM → IDLE with clear_pending cleared.
- **FIFO:**
  - Circular buffer with read and write pointers that wrap at FIFO_DEPTH; a separate count register distinguishes full from empty.
  - A push and pop in the same cycle leaves the count unchanged.
  - No push occurs when full.
- **Ordering:** fragments reach the SRAM in acceptance order. A later fragment to the same address overwrites an earlier one.

## Timing
- Fragment accepted at edge N → LOAD at N+1 (if IDLE) → `O_SRAM_WE_N` low from N+2 through N+1+SRAM_WR_CYCLES.
- Sustained throughput is one fragment per (SRAM_WR_CYCLES+2) cycles, i.e. 4 cycles at the default.
- From full: the pop at LOAD makes `O_FRAG_READY` rise at the following edge.
- `I_FRAME_START` arriving while writes are in flight:
  - The request is latched as pending and ready drops the next cycle.
  - The clear starts only after the FIFO drains and the FSM returns to IDLE.
  - A second pulse during a pending or active clear is ignored.
- Clear duration: FB_PIXELS×(SRAM_WR_CYCLES+2) cycles.

## Configuration
- `FRAG_CLEAR_EN` defined:
  - The CLEAR state, clear address counter, and clear_pending are built.
  - `I_FRAME_START` behaves as described above.
- `FRAG_CLEAR_EN` undefined:
  - `I_FRAME_START` is ignored; no CLEAR state or counter exists.
  - `O_FRAG_READY` = !full.
  - All other behaviour is identical.

## Test plan
- **Reset then single fragment:** addr 18'd1000, color 16'hF800 at edge N.
  - WE_N low exactly for cycles N+2..N+3.
  - `O_SRAM_ADDR`=1000 and `O_SRAM_DATA`=F800 stable from N+1 through N+4.
  - `O_BUSY` falls after RECOVER.
- **Burst of 12 fragments, valid held high, default depth:**
  - Ready drops once the FIFO holds 8.
  - All 12 are written in order, addresses 0..11, with a 4-cycle spacing between WE_N falling edges.
  - No fragment is lost or duplicated.
- **Out-of-range addresses:** addr 256000 and 18'h3FFFF.
  - Both are accepted with no SRAM write; `O_DROP_COUNT`=2.
  - 300 drops saturate the count at 255.
- **Frame clear (`FRAG_CLEAR_EN`, FB_PIXELS=16 for the bench):**
  - Pulse `I_FRAME_START` with 3 fragments queued.
  - The 3 fragments are written first, then addresses 0..15 with 0000.
  - Ready stays low from the pulse until the clear ends.
- **Async reset asserted during WRITE:** WE_N goes high within the same cycle, the FIFO is empty, and after release the first new fragment writes normally.
- **Build without `FRAG_CLEAR_EN`:** an `I_FRAME_START` pulse produces no SRAM activity, and ready follows only FIFO fullness.
